// File: rtl/makestuff_c2f_checksum_pkg.sv
// Types local to the C2F checksum sink.
package c2f_checksum_pkg;

    localparam int C2F_RATE_NBITS = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_DRAIN,
        S_ACK,
        S_WAIT
    } State;

    typedef logic [31:0] CsCount;

endpackage

// File: rtl/makestuff_tlp_xcvr_pkg.sv
// Chunk geometry shared by the TLP transceiver and its C2F consumers.
package makestuff_tlp_xcvr_pkg;

    localparam int C2F_CHUNKSIZE = 128;   // bytes per chunk
    localparam int C2F_NUMCHUNKS = 4;

    typedef logic [63:0]                          uint64;
    typedef logic [$clog2(C2F_NUMCHUNKS)-1:0]     C2FChunkPtr;
    typedef logic [$clog2(C2F_CHUNKSIZE/8)-1:0]   C2FChunkOffset;

endpackage

// File: rtl/makestuff_c2f_checksum_if.sv
// C2F chunk pipe: pointers and acknowledge from/to the transceiver, RAM read port.
interface makestuff_c2f_checksum_if;
    import makestuff_tlp_xcvr_pkg::*;

    C2FChunkPtr    c2fWrPtr_in;
    C2FChunkPtr    c2fRdPtr_in;
    C2FChunkOffset c2fRdOffset_out;
    uint64         c2fRdData_in;
    logic          c2fDTAck_out;

    // Transceiver + RAM side
    modport master (
        output c2fWrPtr_in, c2fRdPtr_in, c2fRdData_in,
        input  c2fRdOffset_out, c2fDTAck_out
    );

    // Consuming side
    modport slave (
        input  c2fWrPtr_in, c2fRdPtr_in, c2fRdData_in,
        output c2fRdOffset_out, c2fDTAck_out
    );
endinterface

// File: rtl/makestuff_c2f_checksum.sv
// Drains each completed C2F chunk QW by QW into a running 64-bit checksum,
// acks the chunk to the transceiver and exposes sum/count for readback.
module makestuff_c2f_checksum
    import makestuff_tlp_xcvr_pkg::*;
    import c2f_checksum_pkg::*;
#(
    parameter int CHUNK_QWS  = C2F_CHUNKSIZE/8,
    parameter int RATE_NBITS = C2F_RATE_NBITS
)(
    input  logic                    pcieClk_in,
    input  logic                    reset_n_in,
    makestuff_c2f_checksum_if.slave c2f,
    input  logic [RATE_NBITS-1:0]   rate_in,
    input  logic                    clear_in,
    output uint64                   csData_out,
    output CsCount                  csCount_out,
    output logic                    csValid_out
);

    localparam C2FChunkOffset LAST_OFS = C2FChunkOffset'(CHUNK_QWS-1);

    State                  state;
    C2FChunkPtr            ptrCap;
    C2FChunkOffset         offset;
    logic [RATE_NBITS-1:0] gap;
    logic                  pend;
    logic                  dtAck;
    logic                  csValid;
    uint64                 csData;
    CsCount                csCount;

    assign c2f.c2fRdOffset_out = offset;
    assign c2f.c2fDTAck_out    = dtAck;
    assign csData_out          = csData;
    assign csCount_out         = csCount;
    assign csValid_out         = csValid;

    // Chunk sequencer: detect, paced QW reads, drain the last read, ack, wait for pointer advance.
    always_ff @(posedge pcieClk_in) begin
        if (!reset_n_in) begin
            state   <= S_IDLE;
            ptrCap  <= '0;
            offset  <= '0;
            gap     <= '0;
            pend    <= 1'b0;
            dtAck   <= 1'b0;
            csValid <= 1'b1;
        end else begin
            pend  <= 1'b0;
            dtAck <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (c2f.c2fWrPtr_in != c2f.c2fRdPtr_in) begin
                        ptrCap  <= c2f.c2fRdPtr_in;
                        offset  <= '0;
                        // First QW issues immediately; rate_in spaces the following ones.
                        gap     <= '0;
                        csValid <= 1'b0;
                        state   <= S_READ;
                    end
                end
                S_READ: begin
                    if (gap == '0) begin
                        pend <= 1'b1;
                        gap  <= rate_in;
                        if (offset == LAST_OFS)
                            state <= S_DRAIN;
                        else
                            offset <= offset + C2FChunkOffset'(1);
                    end else begin
                        gap <= gap - RATE_NBITS'(1);
                    end
                end
                S_DRAIN: begin
                    dtAck <= 1'b1;   // registered so the pulse lines up with S_ACK
                    state <= S_ACK;
                end
                S_ACK: begin
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    // Only leave once the transceiver has moved past this chunk.
                    if (c2f.c2fRdPtr_in != ptrCap) begin
                        csValid <= 1'b1;
                        state   <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Checksum/count accumulation; clear overrides any same-cycle update.
    always_ff @(posedge pcieClk_in) begin
        if (!reset_n_in || clear_in) begin
            csData  <= '0;
            csCount <= '0;
        end else begin
            if (pend)
                csData <= csData + c2f.c2fRdData_in;
            if (state == S_ACK)
                csCount <= csCount + CsCount'(1);
        end
    end

endmodule
